// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions used by the fetch stage: data widths, fetch FSM
// encodings and the PC alignment helper.
package fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Instructions are word aligned, so the two low address bits never reach memory.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter with next-PC selection: sequential increment, live redirect
// (jump over branch) and a latched redirect target for requests still in flight.
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              take_redirect,
  input  logic              latch_redirect,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              redirect,
  output logic              redirect_pend
);

  logic [ADDR_W-1:0] live_target;
  logic [ADDR_W-1:0] pend_target;

  assign redirect    = jump | branch_taken;
  assign live_target = align_pc(jump ? jump_target : branch_target);
  assign pc_plus4    = pc + PC_STEP;

  // A same-cycle redirect is newer than anything latched, so it wins on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= align_pc(RESET_PC);
      pend_target   <= '0;
      redirect_pend <= 1'b0;
    end else if (take_redirect) begin
      pc            <= redirect ? live_target : pend_target;
      redirect_pend <= 1'b0;
    end else if (advance) begin
      pc <= pc_plus4;
    end else if (latch_redirect) begin
      pend_target   <= live_target;
      redirect_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one memory request per instruction and holds
// the returned word for decode, honouring stalls and jump/branch redirects.
//
// state   | meaning
// IDLE    | first cycle out of reset, no request
// REQ     | imem_req high at PC, waiting for imem_ack
// HOLD    | if_* valid, waiting for decode to accept or a redirect
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc_plus4
);

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              redirect;
  logic              redirect_pend;
  logic              advance;
  logic              take_redirect;
  logic              latch_redirect;
  logic              capture;
  logic              clear_valid;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst_n          (rst_n),
    .advance        (advance),
    .take_redirect  (take_redirect),
    .latch_redirect (latch_redirect),
    .jump           (jump),
    .jump_target    (jump_target),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .redirect       (redirect),
    .redirect_pend  (redirect_pend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    advance        = 1'b0;
    take_redirect  = 1'b0;
    latch_redirect = 1'b0;
    capture        = 1'b0;
    clear_valid    = 1'b0;
    case (state)
      ST_IDLE: state_next = ST_REQ;
      ST_REQ: begin
        if (imem_ack) begin
          // Data fetched from the stale path is dropped; re-request at the target.
          if (redirect_pend || redirect) begin
            take_redirect = 1'b1;
          end else begin
            capture    = 1'b1;
            state_next = ST_HOLD;
          end
        end else if (redirect) begin
          latch_redirect = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          take_redirect = 1'b1;
          clear_valid   = 1'b1;
          state_next    = ST_REQ;
        end else if (!stall) begin
          advance     = 1'b1;
          clear_valid = 1'b1;
          state_next  = ST_REQ;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_instr    <= '0;
      if_pc_plus4 <= '0;
    end else if (capture) begin
      if_valid    <= 1'b1;
      if_pc       <= pc;
      if_instr    <= imem_rdata;
      if_pc_plus4 <= pc_plus4;
    end else if (clear_valid) begin
      if_valid <= 1'b0;
    end
  end

  assign imem_req  = (state == ST_REQ);
  assign imem_addr = pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  decode not ready; hold the current fetched instruction.
REQ-005 branch_taken  input  1  redirect to branch_target.
REQ-006 branch_target  input  32  branch destination address.
REQ-007 jump  input  1  redirect to jump_target.
REQ-008 jump_target  input  32  jump destination address.
REQ-009 imem_req  output  1  instruction memory request strobe.
REQ-010 imem_addr  output  32  instruction fetch address, equal to the PC.
REQ-011 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-012 imem_rdata  input  32  instruction word.
REQ-013 if_valid  output  1  if_instr, if_pc and if_pc_plus4 are valid.
REQ-014 if_pc  output  32  address of if_instr.
REQ-015 if_instr  output  32  fetched instruction.
REQ-016 if_pc_plus4  output  32  if_pc + 4, modulo 2^32, for the downstream adder and link path.

Function
REQ-017 The FSM SHALL have states IDLE, REQ and HOLD.
REQ-018 IDLE: imem_req=0; go to REQ on the next edge unconditionally.
REQ-019 REQ: imem_req=1; imem_addr=PC, held stable until imem_ack.
REQ-020 REQ with imem_ack and no pending redirect: capture imem_rdata, PC and PC+4 into the if_* registers, set if_valid=1, and go to HOLD.
REQ-021 An imem_ack in the same cycle as the request SHALL be accepted; if_valid then rises on the next edge, giving a minimum latency of 1 cycle.
REQ-022 HOLD, stall=0, no redirect: PC <= PC+4, if_valid <= 0, and go to REQ.
REQ-023 HOLD, stall=1: all if_* outputs and the PC SHALL stay unchanged.
REQ-024 Redirect priority: jump over branch_taken; redirect target = jump ? jump_target : branch_target.
REQ-025 Redirect in HOLD (regardless of stall): PC <= target, if_valid <= 0, and go to REQ.
REQ-026 Redirect in REQ without imem_ack: latch target and set redirect_pend.
  - imem_addr stays unchanged until imem_ack.
  - A later redirect before imem_ack overwrites the latched target.
REQ-027 imem_ack while redirect_pend=1 or with a same-cycle redirect: discard imem_rdata, keep if_valid=0, load PC with the latest target, clear redirect_pend, and stay in REQ.
REQ-028 PC increment SHALL wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-029 PC bits [1:0] SHALL be forced to 0 on every load, including redirects.
REQ-030 Redirects in IDLE SHALL be ignored.

Reset
REQ-031 On rst_n=0, asynchronously set: state=IDLE, PC=RESET_PC, redirect_pend=0, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, imem_req=0.
REQ-032 Reset assertion mid-request SHALL abandon the request; a subsequent imem_ack while in IDLE is ignored.
REQ-033 The first imem_req SHALL assert in the second cycle after rst_n deasserts (IDLE then REQ).

Structure
REQ-034 FSM state encodings and the instruction width constant (32) SHALL live in the shared CPU package.
REQ-035 The PC register and next-PC selection SHALL be a single sub-module, pc_reg.
REQ-036 The FSM and the if_* pipeline registers SHALL stay in fetch_unit.

Verification
REQ-037 Reset release, imem_ack held at 1, RESET_PC=0: observe fetches at 0x0, 0x4, 0x8 -> if_valid pulses one cycle in every two, if_pc_plus4 = if_pc + 4.
REQ-038 Hold stall=1 for 3 cycles in HOLD with if_pc=0x8 -> if_pc and if_instr stay constant and imem_req=0; after release, the next fetch goes to 0xC.
REQ-039 jump=1 (target 0x100) and branch_taken=1 (target 0x200) together in HOLD -> next imem_addr = 0x100.
REQ-040 branch_taken (target 0x40) while in REQ, imem_ack delayed 3 cycles -> that ack's data is dropped with if_valid=0, then a new request to 0x40 returns if_pc=0x40.
REQ-041 RESET_PC=32'hFFFF_FFFC -> the second fetch goes to 0x0.
REQ-042 Assert rst_n=0 during REQ -> imem_req=0 and if_valid=0 immediately, without waiting for a clock edge.
